// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with a per-register pending-write scoreboard,
// write-back bypass, RAW/WAW issue stalls and flush of outstanding-write state.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_PEND = 3,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rs1,
  input  logic [ADDR_W-1:0] issue_rs2,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              issue_we,
  output logic              issue_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              pend_any
);

  localparam int PEND_W = (MAX_PEND < 1) ? 1 : $clog2(MAX_PEND + 1);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [PEND_W-1:0] r_pend [NUM_REGS];
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rs1_data;
  logic [DATA_W-1:0] r_rs2_data;
  logic              r_pend_any;

  logic [PEND_W-1:0] w_pend_nxt [NUM_REGS];
  logic [PEND_W-1:0] w_src1_pend, w_src2_pend, w_rd_pend;
  logic              w_src1_byp, w_src2_byp;
  logic              w_src1_ready, w_src2_ready;
  logic [DATA_W-1:0] w_src1_data, w_src2_data;
  logic              w_wb_hit, w_waw, w_ready, w_accept, w_inc_ok;
  logic              w_inc, w_dec, w_any;

  // A register is "real" when it has storage and is not the hardwired zero.
  function automatic logic f_writable(input logic [ADDR_W-1:0] a);
    return (int'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    w_src1_pend = '0;
    w_src2_pend = '0;
    w_rd_pend   = '0;
    w_src1_data = '0;
    w_src2_data = '0;
    w_wb_hit    = wb_we && f_writable(wb_rd);
    w_src1_byp  = w_wb_hit && (wb_rd == issue_rs1);
    w_src2_byp  = w_wb_hit && (wb_rd == issue_rs2);
    if (f_writable(issue_rs1)) begin
      w_src1_pend = r_pend[issue_rs1];
      w_src1_data = w_src1_byp ? wb_data : r_regs[issue_rs1];
    end
    if (f_writable(issue_rs2)) begin
      w_src2_pend = r_pend[issue_rs2];
      w_src2_data = w_src2_byp ? wb_data : r_regs[issue_rs2];
    end
    if (f_writable(issue_rd)) w_rd_pend = r_pend[issue_rd];
    // Unscoreboarded sources have zero pending count and are therefore always ready.
    w_src1_ready = (w_src1_pend == '0) || ((w_src1_pend == PEND_W'(1)) && w_src1_byp);
    w_src2_ready = (w_src2_pend == '0) || ((w_src2_pend == PEND_W'(1)) && w_src2_byp);
    w_waw        = issue_we && (w_rd_pend == PEND_W'(MAX_PEND));
    w_ready      = !reset && !flush && w_src1_ready && w_src2_ready && !w_waw;
    w_accept     = issue_valid && w_ready;
    w_inc_ok     = w_accept && issue_we && f_writable(issue_rd);
  end

  assign issue_ready = w_ready;

  // Simultaneous increment and decrement of one counter cancel out.
  always_comb begin
    w_inc = 1'b0;
    w_dec = 1'b0;
    w_any = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_inc         = w_inc_ok && (int'(issue_rd) == r);
      w_dec         = w_wb_hit && (int'(wb_rd) == r) && (r_pend[r] != '0);
      w_pend_nxt[r] = r_pend[r];
      if (flush)               w_pend_nxt[r] = '0;
      else if (w_inc && !w_dec) w_pend_nxt[r] = r_pend[r] + PEND_W'(1);
      else if (w_dec && !w_inc) w_pend_nxt[r] = r_pend[r] - PEND_W'(1);
      w_any = w_any | (r_pend[r] != '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= '0;
        r_pend[r] <= '0;
      end
      r_rd_valid <= 1'b0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_pend_any <= 1'b0;
    end else begin
      if (w_wb_hit) r_regs[wb_rd] <= wb_data;
      for (int r = 0; r < NUM_REGS; r++) r_pend[r] <= w_pend_nxt[r];
      r_pend_any <= w_any;
      r_rd_valid <= w_accept;
      if (w_accept) begin
        r_rs1_data <= w_src1_data;
        r_rs2_data <= w_src2_data;
      end
    end
  end

  assign rd_valid = r_rd_valid;
  assign rs1_data = r_rs1_data;
  assign rs2_data = r_rs2_data;
  assign pend_any = r_pend_any;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset, reads, RAW/WAW stalls, bypass,
// zero register, flush, simultaneous inc/dec and mid-run reset.
module tb_regfile_scoreboard;

  logic        clock;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_we;
  logic        issue_ready;
  logic        rd_valid;
  logic [31:0] rs1_data, rs2_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        pend_any;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  regfile_scoreboard dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_we(issue_we), .issue_ready(issue_ready),
    .rd_valid(rd_valid), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .pend_any(pend_any)
  );

  // Clock and reset drive
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Driver tasks
  task automatic idle();
    issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0; issue_we = 1'b0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic we);
    issue_valid = 1'b1; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd; issue_we = we;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    wb_we = 1'b1; wb_rd = rd; wb_data = d;
  endtask

  // Scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ready(input string tag, input logic exp);
    #1;
    chk(tag, {31'b0, issue_ready}, {31'b0, exp});
  endtask

  task automatic expect_read(input logic [31:0] d1, input logic [31:0] d2);
    exp_q.push_back(d1);
    exp_q.push_back(d2);
  endtask

  task automatic check_read(input string tag);
    logic [31:0] e1, e2;
    e1 = exp_q.pop_front();
    e2 = exp_q.pop_front();
    chk({tag, "_valid"}, {31'b0, rd_valid}, 32'd1);
    chk({tag, "_rs1"}, rs1_data, e1);
    chk({tag, "_rs2"}, rs2_data, e2);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick(); tick();
    chk_ready("rst_ready", 1'b0);
    chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("rst_rs1", rs1_data, 32'd0);
    chk("rst_rs2", rs2_data, 32'd0);
    chk("rst_pend_any", {31'b0, pend_any}, 32'd0);
    reset = 1'b0;

    // Plain reads
    issue(5'd3, 5'd0, 5'd0, 1'b0); chk_ready("rd0_ready", 1'b1); expect_read(32'd0, 32'd0);
    tick(); idle(); check_read("rd0");
    chk("rd0_pend_any", {31'b0, pend_any}, 32'd0);
    tick(); chk("rd_valid_drop", {31'b0, rd_valid}, 32'd0);
    wb(5'd3, 32'hA5A5_0003); tick(); idle();
    issue(5'd3, 5'd3, 5'd0, 1'b0); chk_ready("rd3_ready", 1'b1);
    expect_read(32'hA5A5_0003, 32'hA5A5_0003);
    tick(); idle(); check_read("rd3");

    // RAW stall then bypass
    issue(5'd0, 5'd0, 5'd5, 1'b1); chk_ready("raw_wr_ready", 1'b1);
    tick(); idle();
    issue(5'd5, 5'd0, 5'd0, 1'b0); chk_ready("raw_stall", 1'b0);
    tick();
    chk("raw_no_valid", {31'b0, rd_valid}, 32'd0);
    chk("raw_pend_any", {31'b0, pend_any}, 32'd1);
    wb(5'd5, 32'hDEAD_BEEF); chk_ready("raw_bypass_ready", 1'b1);
    expect_read(32'hDEAD_BEEF, 32'd0);
    tick(); idle(); check_read("raw_bypass");
    tick(); chk("raw_pend_any_clr", {31'b0, pend_any}, 32'd0);

    // WAW saturation on r7
    for (int i = 0; i < 3; i++) begin
      issue(5'd0, 5'd0, 5'd7, 1'b1); chk_ready("waw_issue", 1'b1);
      tick();
    end
    issue(5'd0, 5'd0, 5'd7, 1'b1); chk_ready("waw_sat", 1'b0);
    wb(5'd7, 32'h71); chk_ready("waw_sat_wb", 1'b0);
    tick(); idle();
    issue(5'd0, 5'd0, 5'd7, 1'b1); chk_ready("waw_reissue", 1'b1);
    tick();
    chk_ready("waw_resat", 1'b0);
    idle();
    wb(5'd7, 32'h72); tick();
    wb(5'd7, 32'h73); tick();
    wb(5'd7, 32'h74); tick(); idle();
    issue(5'd7, 5'd0, 5'd0, 1'b0); chk_ready("waw_drained", 1'b1);
    expect_read(32'h74, 32'd0);
    tick(); idle(); check_read("waw_read");

    // Zero register
    wb(5'd0, 32'h1234); tick(); idle();
    issue(5'd0, 5'd7, 5'd0, 1'b0); wb(5'd0, 32'h1234); chk_ready("zero_ready", 1'b1);
    expect_read(32'd0, 32'h74);
    tick(); idle(); check_read("zero_read");
    issue(5'd0, 5'd0, 5'd0, 1'b1); chk_ready("zero_wr_ready", 1'b1);
    tick(); idle(); tick(); tick();
    chk("zero_pend_any", {31'b0, pend_any}, 32'd0);

    // Flush with r2 and r9 pending
    issue(5'd0, 5'd0, 5'd2, 1'b1); tick();
    issue(5'd0, 5'd0, 5'd9, 1'b1); tick(); idle();
    chk("flush_pre_pend_any", {31'b0, pend_any}, 32'd1);
    issue(5'd2, 5'd0, 5'd0, 1'b0); flush = 1'b1; chk_ready("flush_stall", 1'b0);
    tick(); flush = 1'b0;
    chk("flush_no_valid", {31'b0, rd_valid}, 32'd0);
    issue(5'd2, 5'd9, 5'd0, 1'b0); chk_ready("flush_after_ready", 1'b1);
    expect_read(32'd0, 32'd0);
    tick(); idle(); check_read("flush_read");
    chk("flush_pend_any", {31'b0, pend_any}, 32'd0);
    wb(5'd2, 32'h55); tick(); idle();
    issue(5'd2, 5'd9, 5'd0, 1'b0); chk_ready("late_wb_ready", 1'b1);
    expect_read(32'h55, 32'd0);
    tick(); idle(); check_read("late_wb_read");
    tick(); chk("late_wb_pend_any", {31'b0, pend_any}, 32'd0);

    // Simultaneous increment and decrement on r4
    issue(5'd0, 5'd0, 5'd4, 1'b1); tick();
    issue(5'd0, 5'd0, 5'd4, 1'b1); wb(5'd4, 32'h44); chk_ready("incdec_ready", 1'b1);
    tick(); idle();
    issue(5'd4, 5'd0, 5'd0, 1'b0); chk_ready("incdec_stall", 1'b0);
    tick(); idle();
    wb(5'd4, 32'h4444); tick(); idle();
    issue(5'd4, 5'd0, 5'd0, 1'b0); chk_ready("incdec_ready2", 1'b1);
    expect_read(32'h4444, 32'd0);
    tick(); idle(); check_read("incdec_read");

    // Same-cycle write and read of an idle register forwards new data
    issue(5'd10, 5'd3, 5'd0, 1'b0); wb(5'd10, 32'hCAFE); chk_ready("fwd_ready", 1'b1);
    expect_read(32'hCAFE, 32'hA5A5_0003);
    tick(); idle(); check_read("fwd_read");

    // Reset mid-operation discards pending state and a coincident write-back
    issue(5'd0, 5'd0, 5'd6, 1'b1); tick(); idle();
    reset = 1'b1; wb(5'd3, 32'hFFFF); tick(); reset = 1'b0; idle();
    chk("mid_rst_valid", {31'b0, rd_valid}, 32'd0);
    issue(5'd3, 5'd6, 5'd0, 1'b0); chk_ready("mid_rst_ready", 1'b1);
    expect_read(32'd0, 32'd0);
    tick(); idle(); check_read("mid_rst_read");

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the CPU's two-read/one-write register file.
- Adds a per-register scoreboard that tracks outstanding writes from the execute/memory/write-back pipeline.
- Adds same-cycle write-back bypass, issue stall generation (RAW/WAW) and flush handling.
- Sits between the instruction register (issue side) and the write-back mux (`din` side). It replaces the separate read and write register-file instances in the CPU top.

Parameters:
- DATA_W, 32, register data width in bits
- NUM_REGS, 32, number of architectural registers
- ADDR_W, 5, register index width; must satisfy 2^ADDR_W >= NUM_REGS
- MAX_PEND, 3, maximum outstanding writes per register (pipeline depth from issue to write-back)
- ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes and is never scoreboarded

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- issue_valid  in  1  instruction presented for issue
- issue_rs1  in  ADDR_W  source register 1
- issue_rs2  in  ADDR_W  source register 2
- issue_rd  in  ADDR_W  destination register
- issue_we  in  1  instruction will write issue_rd
- issue_ready  out  1  combinational; issue accepted this cycle when issue_valid && issue_ready
- rd_valid  out  1  registered; read data below is valid
- rs1_data  out  DATA_W  registered operand 1
- rs2_data  out  DATA_W  registered operand 2
- wb_we  in  1  write-back strobe (register_we from final stage)
- wb_rd  in  ADDR_W  write-back destination
- wb_data  in  DATA_W  write-back data
- flush  in  1  discard scoreboard state (branch/jump taken)
- pend_any  out  1  registered; OR of all pending counters nonzero

Behaviour:
- Reset: all registers 0, all pending counters 0; rd_valid, rs1_data, rs2_data, pend_any = 0. Reset has priority over flush, issue and write-back. Reset mid-operation discards everything; a write-back arriving in the same cycle is ignored.
- Storage: NUM_REGS x DATA_W flops.
- Write: on a clock edge with wb_we, reg[wb_rd] <= wb_data. Ignored when ZERO_REG and wb_rd == 0. Ignored when wb_rd >= NUM_REGS.
- Pending counter: pend[r], width clog2(MAX_PEND+1).
  - Increment: on accepted issue with issue_we, for r = issue_rd (not r0 when ZERO_REG).
  - Decrement: on wb_we for r = wb_rd. A decrement at 0 is ignored; no underflow.
  - Same cycle, same register, increment and decrement: counter unchanged.
- Source "ready", per source s:
  - ZERO_REG and s == 0, or
  - pend[s] == 0, or
  - pend[s] == 1 && wb_we && wb_rd == s (bypass case).
- issue_ready = ~reset && ~flush && src1_ready && src2_ready && ~(issue_we && pend[issue_rd] == MAX_PEND). The last term is the WAW saturation stall.
- Read latency is 1 cycle. On an accepted issue:
  - rd_valid <= 1 next cycle.
  - rsN_data <= wb_data if the bypass applies, else reg[rsN]; 0 for r0 when ZERO_REG.
  - Otherwise rd_valid <= 0 and rsN_data holds its value.
- Out-of-range source index (>= NUM_REGS) reads 0 and is treated as ready.
- Flush:
  - All pending counters clear next cycle; no issue is accepted that cycle.
  - The register write in that cycle still occurs.
  - Write-backs after the flush write data normally; their decrements saturate at 0.
- pend_any updates one cycle after the counters change.
- Same-cycle read and write to the same register with pend == 0: new data is forwarded. This case cannot occur legally but must not return stale data.

Test Plan:
- Reset then read: assert reset 2 cycles; issue rs1 = 3, rs2 = 0 -> issue_ready = 1, next cycle rd_valid = 1, rs1_data = 0, rs2_data = 0, pend_any = 0.
- RAW stall and bypass:
  - Issue rd = 5 with issue_we; next cycle issue rs1 = 5 -> issue_ready = 0.
  - Later cycle with wb_we, wb_rd = 5, wb_data = 0xDEADBEEF -> issue_ready = 1, next cycle rs1_data = 0xDEADBEEF.
- WAW saturation: issue three writes to rd = 7 (MAX_PEND = 3) without write-back -> 4th write issue to rd = 7 gives issue_ready = 0. One wb to r7 -> ready again; pend[7] stays 3 after the re-issue.
- Zero register: wb_we, wb_rd = 0, wb_data = 0x1234 -> subsequent read of r0 returns 0. Issue rd = 0 with issue_we -> pend_any stays 0.
- Flush:
  - Pending writes to r2 and r9, assert flush -> issue_ready = 0 that cycle; next cycle pend_any = 0 and reads of r2 are accepted.
  - A late wb to r2 with 0x55 writes r2 = 0x55 and leaves no counter underflow.
- Simultaneous inc/dec: pend[4] = 1; same cycle accept issue rd = 4 and wb_rd = 4 -> pend[4] stays 1. A read of r4 that cycle stalls; the next read after one further wb returns the latest data.
